weight_stream_loader: RTL and testbench

Upstream feeder of the weight memory: accepts weight beats from the HWPE streamer over a valid/ready stream, packs them into full N_DIM_ARRAY-wide rows, and issues registered row writes on either the FC or CNN external write port. Row addresses are generated from a programmable base and counter. The address MSB selects the ping-pong bank, so one bank can be refilled while the accelerator reads the other.

---
 rtl/weight_stream_loader.sv | 196 +++++++++++++++++++
 tb/tb_weight_stream_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader
// Collects weight beats from a valid/ready stream, packs BPR beats into one
// N_DIM_ARRAY-wide row and issues a registered row write on the FC or CNN
// weight-memory port. Row address = {bank, base + row index}. The offset wraps
// inside the bank.
// Optional feature macro: WEIGHT_LOADER_AUTO_PINGPONG_EN. When it is defined,
// the bank alternates on every completed load and bank_sel is ignored.
module weight_stream_loader #(
   parameter int N_DIM_ARRAY             = 8,
   parameter int WEIGHT_DATA_WIDTH       = 8,
   parameter int WEIGHT_MEMORY_ADDR_SIZE = 16,
   parameter int IN_WIDTH                = 32
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic                                               clear,
   input  logic                                               mode,
   input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]                 base_addr,
   input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]                 num_rows,
   input  logic                                               bank_sel,
   input  logic                                               s_valid,
   input  logic [IN_WIDTH-1:0]                                s_data,
   output logic                                               s_ready,
   output logic                                               wr_en_fc,
   output logic                                               wr_en_cnn,
   output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]                 wr_addr,
   output logic signed [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]    wr_data,
   output logic                                               busy,
   output logic                                               done,
   output logic                                               bank_out
);

   localparam int ROW_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
   localparam int BPR   = ROW_W / IN_WIDTH;
   localparam int BW    = (BPR > 1) ? $clog2(BPR) : 1;
   localparam int OW    = WEIGHT_MEMORY_ADDR_SIZE - 1;

   localparam logic [BW-1:0] BEAT_LAST = BW'(BPR - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [OW-1:0] OFF_ONE   = OW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_LAST = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_r;
   logic [1:0]       state_next_s;
   logic             mode_r;
   logic [OW-1:0]    base_r;
   logic [OW-1:0]    num_rows_r;
   logic             bank_r;
   logic [BW-1:0]    beat_r;
   logic [OW-1:0]    row_idx_r;
   logic [ROW_W-1:0] row_buf_r;
   logic [ROW_W-1:0] row_next_s;
   logic             s_ready_s;
   logic             accept_s;
   logic             row_done_s;
   logic             final_row_s;
   logic             load_bank_s;

`ifdef WEIGHT_LOADER_AUTO_PINGPONG_EN
   logic pp_bank_r;
   logic unused_bank_sel_s;

   // Bank for the next load flips whenever a load reaches DONE; an aborted load keeps it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pp_bank_r <= 1'b0;
      end else if (!clear && (state_r == ST_DONE)) begin
         pp_bank_r <= ~pp_bank_r;
      end else begin
         pp_bank_r <= pp_bank_r;
      end
   end

   assign load_bank_s       = pp_bank_r;
   assign unused_bank_sel_s = bank_sel;
`else
   assign load_bank_s = bank_sel;
`endif

   // Stream handshake: ready depends only on state and counters, never on s_valid.
   always_comb begin
      s_ready_s   = (state_r == ST_LOAD) && (row_idx_r < num_rows_r);
      accept_s    = s_valid && s_ready_s;
      row_done_s  = accept_s && (beat_r == BEAT_LAST);
      final_row_s = (row_idx_r == (num_rows_r - OFF_ONE));
   end

   // Row image including the beat accepted this cycle; lane l of beat b is element b*lanes+l.
   always_comb begin
      row_next_s = row_buf_r;
      for (int b = 0; b < BPR; b++) begin
         if (accept_s && (beat_r == BW'(b))) begin
            row_next_s[b*IN_WIDTH +: IN_WIDTH] = s_data;
         end else begin
            row_next_s[b*IN_WIDTH +: IN_WIDTH] = row_buf_r[b*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   // Next-state logic; clear wins over everything, start counts only in IDLE.
   always_comb begin
      state_next_s = state_r;
      if (clear) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_next_s = (num_rows == {OW{1'b0}}) ? ST_DONE : ST_LOAD;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (row_done_s && final_row_s) begin
                  state_next_s = ST_LAST;
               end else begin
                  state_next_s = ST_LOAD;
               end
            end
            ST_LAST: state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
         endcase
      end
   end

   // State, latched load parameters, beat/row counters and the partial row buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         mode_r     <= 1'b0;
         base_r     <= {OW{1'b0}};
         num_rows_r <= {OW{1'b0}};
         bank_r     <= 1'b0;
         beat_r     <= {BW{1'b0}};
         row_idx_r  <= {OW{1'b0}};
         row_buf_r  <= {ROW_W{1'b0}};
      end else if (clear) begin
         state_r   <= ST_IDLE;
         beat_r    <= {BW{1'b0}};
         row_idx_r <= {OW{1'b0}};
      end else begin
         state_r <= state_next_s;
         if ((state_r == ST_IDLE) && start) begin
            mode_r     <= mode;
            base_r     <= base_addr;
            num_rows_r <= num_rows;
            bank_r     <= load_bank_s;
            beat_r     <= {BW{1'b0}};
            row_idx_r  <= {OW{1'b0}};
         end else if (accept_s) begin
            row_buf_r <= row_next_s;
            if (row_done_s) begin
               beat_r    <= {BW{1'b0}};
               row_idx_r <= row_idx_r + OFF_ONE;
            end else begin
               beat_r <= beat_r + BEAT_ONE;
            end
         end
      end
   end

   // Registered write port and status; wr_addr/wr_data hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_fc  <= 1'b0;
         wr_en_cnn <= 1'b0;
         wr_addr   <= {WEIGHT_MEMORY_ADDR_SIZE{1'b0}};
         wr_data   <= {ROW_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= (state_next_s != ST_IDLE);
         done <= (state_next_s == ST_DONE);
         if (row_done_s && !clear) begin
            wr_en_fc  <= ~mode_r;
            wr_en_cnn <= mode_r;
            wr_addr   <= {bank_r, base_r + row_idx_r};
            wr_data   <= row_next_s;
         end else begin
            wr_en_fc  <= 1'b0;
            wr_en_cnn <= 1'b0;
         end
      end
   end

   assign s_ready  = s_ready_s;
   assign bank_out = bank_r;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Self-checking bench for weight_stream_loader (default parameters, BPR = 2).
// Randomized rows are generated first; the reference model derives the expected
// write list (address, row, port) directly from the load request, and a
// monitor matches each observed write against it in order.
module tb_weight_stream_loader;

   localparam int NW  = 8;
   localparam int WW  = 8;
   localparam int AW  = 16;
   localparam int IW  = 32;
   localparam int OW  = AW - 1;
   localparam int RW  = NW * WW;
   localparam int BPR = RW / IW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          clear;
   logic          mode;
   logic [OW-1:0] base_addr;
   logic [OW-1:0] num_rows;
   logic          bank_sel;
   logic          s_valid;
   logic [IW-1:0] s_data;
   logic          s_ready;
   logic          wr_en_fc;
   logic          wr_en_cnn;
   logic [AW-1:0] wr_addr;
   logic signed [RW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          bank_out;

   typedef struct {
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
      logic          mode;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_w;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   int   last_wr_cyc = 0;
   int   done_cyc = 0;
   int   prev_wr_cyc = -1;
   int   start_cyc = 0;
   bit   rate_chk = 1'b0;
   logic pp_bank = 1'b0;

   weight_stream_loader #(
      .N_DIM_ARRAY(NW),
      .WEIGHT_DATA_WIDTH(WW),
      .WEIGHT_MEMORY_ADDR_SIZE(AW),
      .IN_WIDTH(IW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .mode(mode),
      .base_addr(base_addr), .num_rows(num_rows), .bank_sel(bank_sel),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .wr_en_fc(wr_en_fc), .wr_en_cnn(wr_en_cnn), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .bank_out(bank_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model of which bank a new load targets.
   function automatic logic bank_for(input logic sel);
`ifdef WEIGHT_LOADER_AUTO_PINGPONG_EN
      return pp_bank;
`else
      return sel;
`endif
   endfunction

   // Write/done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_en_fc || wr_en_cnn) begin
         check("wr_onehot", 64'(wr_en_fc & wr_en_cnn), 64'd0);
         check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_w = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(mon_w.addr));
            check("wr_data", wr_data, mon_w.data);
            check("wr_port_cnn", 64'(wr_en_cnn), 64'(mon_w.mode));
         end
         if (rate_chk && (prev_wr_cyc >= 0)) begin
            check("row_rate", 64'(cyc - prev_wr_cyc), 64'(BPR));
         end
         prev_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic do_start(input logic m, input logic [OW-1:0] base, input logic [OW-1:0] n,
                           input logic bs);
      @(posedge clk); #1;
      start = 1'b1; mode = m; base_addr = base; num_rows = n; bank_sel = bs;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      mode = 1'($urandom); base_addr = OW'($urandom);
      num_rows = OW'($urandom); bank_sel = 1'($urandom);
      check("s_ready_after_start", 64'(s_ready), 64'(n != '0));
   endtask

   task automatic send_beat(input logic [IW-1:0] d, input int pct);
      int   guard = 0;
      logic acc = 1'b0;
      while (!acc && guard < 200) begin
         s_valid = ($urandom_range(0, 99) < pct);
         s_data  = s_valid ? d : IW'($urandom);
         acc     = s_valid && s_ready;
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 1'b0;
      if (!acc) check("beat_timeout", 64'(acc), 64'd1);
   endtask

   task automatic wait_done(input int mark);
      int g = 0;
      while (done_cnt == mark && g < 10) begin
         @(posedge clk); #1;
         g++;
      end
      check("done_pulses", 64'(done_cnt - mark), 64'd1);
   endtask

   task automatic run_load(input logic m, input logic [OW-1:0] base, input int n,
                           input logic bs, input int pct);
      logic [RW-1:0] rows[$];
      logic [RW-1:0] row;
      wr_t           w;
      logic          b;
      int            mark_d;
      b = bank_for(bs);
      mark_d = done_cnt;
      prev_wr_cyc = -1;
      rate_chk = (pct == 100);
      for (int r = 0; r < n; r++) begin
         row = {$urandom, $urandom};
         rows.push_back(row);
         w.addr = {b, OW'(int'(base) + r)};
         w.data = row;
         w.mode = m;
         exp_q.push_back(w);
      end
      do_start(m, base, OW'(n), bs);
      for (int r = 0; r < n; r++) begin
         row = rows[r];
         for (int k = 0; k < BPR; k++) send_beat(row[k*IW +: IW], pct);
      end
      check("s_ready_final", 64'(s_ready), 64'd0);
      wait_done(mark_d);
      check("done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      check("bank_out", 64'(bank_out), 64'(b));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      pp_bank = ~pp_bank;
      rate_chk = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int            mark_w;
      int            mark_d;
      int            lat;
      logic [RW-1:0] r0;
      logic [RW-1:0] r1;
      logic [RW-1:0] r2;
      wr_t           w;

      reset = 1'b0; start = 1'b0; clear = 1'b0; mode = 1'b0; base_addr = '0;
      num_rows = '0; bank_sel = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_wr_en_fc", 64'(wr_en_fc), 64'd0);
      check("rst_wr_en_cnn", 64'(wr_en_cnn), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_bank_out", 64'(bank_out), 64'd0);
      reset = 1'b1;

      // FC load, 3 rows from 0x0010, bank 0, continuous valid
      run_load(1'b0, 15'h0010, 3, 1'b0, 100);
      // CNN load, 2 rows from 0x7FFF, bank 1: offset wraps inside the bank
      run_load(1'b1, 15'h7FFF, 2, 1'b1, 100);
      // 16 rows with 50% valid gaps, random configuration
      run_load(1'($urandom), OW'($urandom), 16, 1'($urandom), 50);

      // num_rows == 0: no writes, s_ready stays low, one done pulse
      mark_w = wr_cnt; mark_d = done_cnt;
      do_start(1'b0, 15'h0040, 15'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("zero_s_ready", 64'(s_ready), 64'd0);
         @(posedge clk); #1;
      end
      lat = done_cyc - start_cyc;
      check("zero_done_pulses", 64'(done_cnt - mark_d), 64'd1);
      check("zero_done_latency", 64'((lat >= 1) && (lat <= 2)), 64'd1);
      check("zero_no_writes", 64'(wr_cnt - mark_w), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
      pp_bank = ~pp_bank;

      // clear in the middle of row 2 of a 5-row load
      mark_w = wr_cnt; mark_d = done_cnt;
      r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
      w.mode = 1'b0; w.addr = {bank_for(1'b0), 15'h0200}; w.data = r0; exp_q.push_back(w);
      w.addr = {bank_for(1'b0), 15'h0201}; w.data = r1; exp_q.push_back(w);
      do_start(1'b0, 15'h0200, 15'd5, 1'b0);
      for (int k = 0; k < BPR; k++) send_beat(r0[k*IW +: IW], 100);
      for (int k = 0; k < BPR; k++) send_beat(r1[k*IW +: IW], 100);
      send_beat(r2[IW-1:0], 100);
      clear = 1'b1; s_valid = 1'b1; s_data = r2[2*IW-1:IW];
      @(posedge clk); #1;
      clear = 1'b0; s_valid = 1'b0;
      check("clear_busy", 64'(busy), 64'd0);
      check("clear_s_ready", 64'(s_ready), 64'd0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("clear_writes", 64'(wr_cnt - mark_w), 64'd2);
      check("clear_no_done", 64'(done_cnt - mark_d), 64'd0);
      check("clear_queue", 64'(exp_q.size()), 64'd0);
      run_load(1'b0, 15'h0200, 2, 1'b0, 100);

      // three back-to-back loads with random bank_sel
      for (int i = 0; i < 3; i++) begin
         run_load(1'($urandom), OW'($urandom), 1 + $urandom_range(0, 2), 1'($urandom), 100);
      end

      // asynchronous reset in the middle of a load
      r0 = {$urandom, $urandom};
      w.mode = 1'b1; w.addr = {bank_for(1'b1), 15'h0300}; w.data = r0; exp_q.push_back(w);
      do_start(1'b1, 15'h0300, 15'd4, 1'b1);
      for (int k = 0; k < BPR; k++) send_beat(r0[k*IW +: IW], 100);
      send_beat(IW'($urandom), 100);
      reset = 1'b0;
      #1;
      check("arst_s_ready", 64'(s_ready), 64'd0);
      check("arst_wr_en_fc", 64'(wr_en_fc), 64'd0);
      check("arst_wr_en_cnn", 64'(wr_en_cnn), 64'd0);
      check("arst_wr_addr", 64'(wr_addr), 64'd0);
      check("arst_wr_data", wr_data, 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_bank_out", 64'(bank_out), 64'd0);
      check("arst_queue", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      pp_bank = 1'b0;
      #2;
      reset = 1'b1;
      run_load(1'b0, 15'h0000, 2, 1'b1, 50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
